// File: rtl/btn_decoder_seq.sv
// Button decoder: synchronizes, debounces and encodes a bank of push buttons.
// It issues one held one-hot selection per press, or flags a rejected multi-press.
//
// Ports:
//   clk     - sole clock; all state changes on the rising edge
//   rst     - synchronous, active-high reset
//   btn     - raw asynchronous button levels, 1 = pressed
//   ack     - consumer acknowledge; releases the held selection
//   sig     - registered one-hot selection, zero when nothing is held
//   code    - registered binary index of the set sig bit, zero when sig is zero
//   valid   - registered, high exactly while sig is non-zero
//   invalid - registered one-cycle pulse when a multi-press is rejected
module btn_decoder_seq #(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 4,
    parameter int MODE       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn,
    input  logic                     ack,
    output logic [N_BTN-1:0]         sig,
    output logic [$clog2(N_BTN)-1:0] code,
    output logic                     valid,
    output logic                     invalid
);

    localparam int CW    = $clog2(N_BTN);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [N_BTN-1:0] ONE     = N_BTN'(1);
    localparam logic             PRIO    = (MODE == 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOLD     = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [N_BTN-1:0] cand;
    logic [N_BTN-1:0] db;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;

    logic             multi;
    logic [N_BTN-1:0] low_sig;
    logic [CW-1:0]    low_idx;

    // db & -db isolates the lowest set bit; for a one-hot db it is db itself.
    always_comb begin
        multi   = |(db & (db - ONE));
        low_sig = db & (~db + ONE);
        low_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (db[i]) begin
                low_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            cand    <= '0;
            cnt     <= '0;
            db      <= '0;
            sig     <= '0;
            code    <= '0;
            valid   <= 1'b0;
            invalid <= 1'b0;
            state   <= IDLE;
        end else begin
            s1 <= btn;
            s2 <= s1;

            // Any change restarts the count; db follows cand only once cand
            // has been seen unchanged for DEB_CYCLES consecutive cycles.
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                db <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            invalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (db != '0) begin
                        if (!multi || PRIO) begin
                            sig   <= low_sig;
                            code  <= low_idx;
                            valid <= 1'b1;
                            state <= HOLD;
                        end else begin
                            invalid <= 1'b1;
                            state   <= WAIT_REL;
                        end
                    end
                end
                HOLD: begin
                    if (ack) begin
                        sig   <= '0;
                        code  <= '0;
                        valid <= 1'b0;
                        state <= (db == '0) ? IDLE : WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    // Block re-triggering until every button is released.
                    if (db == '0) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_decoder_seq.sv
// Directed bench for btn_decoder_seq: a reject-mode and a priority-mode
// instance share the stimulus; each scenario task checks its own vectors.
module tb_btn_decoder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = '0;
    logic       ack = 1'b0;

    logic [3:0] sig0;
    logic [1:0] code0;
    logic       valid0;
    logic       invalid0;
    logic [3:0] sig1;
    logic [1:0] code1;
    logic       valid1;
    logic       invalid1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    btn_decoder_seq #(.N_BTN(4), .DEB_CYCLES(4), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .btn(btn), .ack(ack),
        .sig(sig0), .code(code0), .valid(valid0), .invalid(invalid0)
    );

    btn_decoder_seq #(.N_BTN(4), .DEB_CYCLES(4), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .btn(btn), .ack(ack),
        .sig(sig1), .code(code1), .valid(valid1), .invalid(invalid1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with buttons released; the next edge is edge 1 with btn = b.
    task automatic restart(input logic [3:0] b);
        rst = 1'b1;
        btn = '0;
        ack = 1'b0;
        tick();
        rst = 1'b0;
        btn = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 4'b0100;
        tick();
        tick();
        vectors++;
        if ({sig0, code0, valid0, invalid0} !== 8'h00) begin
            errors++;
            $display("FAIL reset m0: sig=%b code=%0d v=%b inv=%b, want all 0",
                     sig0, code0, valid0, invalid0);
        end
        vectors++;
        if ({sig1, code1, valid1, invalid1} !== 8'h00) begin
            errors++;
            $display("FAIL reset m1: sig=%b code=%0d v=%b inv=%b, want all 0",
                     sig1, code1, valid1, invalid1);
        end
    endtask

    task automatic test_press_ack();
        restart(4'b0100);
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0000 || valid0 !== 1'b0) begin
                errors++;
                $display("FAIL press early e%0d: sig=%b v=%b, want 0000/0",
                         e, sig0, valid0);
            end
        end
        tick();
        vectors++;
        if (sig0 !== 4'b0100 || code0 !== 2'd2 || valid0 !== 1'b1
            || invalid0 !== 1'b0) begin
            errors++;
            $display("FAIL press e8: sig=%b code=%0d v=%b inv=%b, want 0100/2/1/0",
                     sig0, code0, valid0, invalid0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0100 || valid0 !== 1'b1) begin
                errors++;
                $display("FAIL press hold %0d: sig=%b v=%b, want 0100/1",
                         k, sig0, valid0);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (sig0 !== 4'b0000 || code0 !== 2'd0 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL press ack: sig=%b code=%0d v=%b, want 0000/0/0",
                     sig0, code0, valid0);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0000 || valid0 !== 1'b0) begin
                errors++;
                $display("FAIL no repeat %0d: sig=%b v=%b, want 0000/0",
                         k, sig0, valid0);
            end
        end
    endtask

    task automatic test_glitch();
        restart(4'b0010);
        tick();
        tick();
        btn = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0000 || valid0 !== 1'b0 || invalid0 !== 1'b0) begin
                errors++;
                $display("FAIL glitch %0d: sig=%b v=%b inv=%b, want 0/0/0",
                         k, sig0, valid0, invalid0);
            end
        end
    endtask

    task automatic test_multi_reject();
        restart(4'b0110);
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if (invalid0 !== 1'b0 || sig0 !== 4'b0000) begin
                errors++;
                $display("FAIL multi early e%0d: inv=%b sig=%b, want 0/0000",
                         e, invalid0, sig0);
            end
        end
        tick();
        vectors++;
        if (invalid0 !== 1'b1 || sig0 !== 4'b0000 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL multi e8: inv=%b sig=%b v=%b, want 1/0000/0",
                     invalid0, sig0, valid0);
        end
        tick();
        vectors++;
        if (invalid0 !== 1'b0) begin
            errors++;
            $display("FAIL multi pulse e9: inv=%b, want 0", invalid0);
        end
        // Narrowing to a single button without release must not register.
        btn = 4'b0100;
        for (int k = 0; k < 14; k++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0000 || invalid0 !== 1'b0) begin
                errors++;
                $display("FAIL wait_rel %0d: sig=%b inv=%b, want 0000/0",
                         k, sig0, invalid0);
            end
        end
    endtask

    task automatic test_back_to_back();
        btn = 4'b0000;
        for (int k = 0; k < 12; k++) tick();
        btn = 4'b0010;
        for (int e = 1; e <= 7; e++) tick();
        vectors++;
        if (sig0 !== 4'b0000) begin
            errors++;
            $display("FAIL b2b e7: sig=%b, want 0000", sig0);
        end
        tick();
        vectors++;
        if (sig0 !== 4'b0010 || code0 !== 2'd1 || valid0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b e8: sig=%b code=%0d v=%b, want 0010/1/1",
                     sig0, code0, valid0);
        end
    endtask

    task automatic test_priority();
        restart(4'b1010);
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if (invalid1 !== 1'b0 || sig1 !== 4'b0000) begin
                errors++;
                $display("FAIL prio early e%0d: inv=%b sig=%b, want 0/0000",
                         e, invalid1, sig1);
            end
        end
        tick();
        vectors++;
        if (sig1 !== 4'b0010 || code1 !== 2'd1 || valid1 !== 1'b1
            || invalid1 !== 1'b0) begin
            errors++;
            $display("FAIL prio e8: sig=%b code=%0d v=%b inv=%b, want 0010/1/1/0",
                     sig1, code1, valid1, invalid1);
        end
        vectors++;
        if (invalid0 !== 1'b1 || sig0 !== 4'b0000) begin
            errors++;
            $display("FAIL prio m0 e8: inv=%b sig=%b, want 1/0000",
                     invalid0, sig0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (invalid1 !== 1'b0 || sig1 !== 4'b0010) begin
                errors++;
                $display("FAIL prio hold %0d: inv=%b sig=%b, want 0/0010",
                         k, invalid1, sig1);
            end
        end
    endtask

    task automatic test_hold_change();
        restart(4'b0001);
        for (int e = 1; e <= 8; e++) tick();
        vectors++;
        if (sig0 !== 4'b0001 || code0 !== 2'd0 || valid0 !== 1'b1) begin
            errors++;
            $display("FAIL hchg e8: sig=%b code=%0d v=%b, want 0001/0/1",
                     sig0, code0, valid0);
        end
        btn = 4'b1000;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0001 || valid0 !== 1'b1) begin
                errors++;
                $display("FAIL hchg hold %0d: sig=%b v=%b, want 0001/1",
                         k, sig0, valid0);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (sig0 !== 4'b0000 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL hchg ack: sig=%b v=%b, want 0000/0", sig0, valid0);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0000 || valid0 !== 1'b0) begin
                errors++;
                $display("FAIL hchg held %0d: sig=%b v=%b, want 0000/0",
                         k, sig0, valid0);
            end
        end
        btn = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0000) begin
                errors++;
                $display("FAIL hchg rel %0d: sig=%b, want 0000", k, sig0);
            end
        end
    endtask

    task automatic test_ack_idle();
        restart(4'b0000);
        ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({sig0, code0, valid0, invalid0} !== 8'h00) begin
                errors++;
                $display("FAIL ack idle %0d: sig=%b v=%b inv=%b, want 0",
                         k, sig0, valid0, invalid0);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        restart(4'b0100);
        for (int e = 1; e <= 10; e++) tick();
        vectors++;
        if (sig0 !== 4'b0100) begin
            errors++;
            $display("FAIL rhold pre: sig=%b, want 0100", sig0);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({sig0, code0, valid0, invalid0} !== 8'h00) begin
            errors++;
            $display("FAIL rhold rst: sig=%b code=%0d v=%b inv=%b, want 0",
                     sig0, code0, valid0, invalid0);
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if (sig0 !== 4'b0000 || valid0 !== 1'b0) begin
                errors++;
                $display("FAIL rhold early e%0d: sig=%b v=%b, want 0000/0",
                         e, sig0, valid0);
            end
        end
        tick();
        vectors++;
        if (sig0 !== 4'b0100 || code0 !== 2'd2 || valid0 !== 1'b1) begin
            errors++;
            $display("FAIL rhold e8: sig=%b code=%0d v=%b, want 0100/2/1",
                     sig0, code0, valid0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_press_ack();
        test_glitch();
        test_multi_reject();
        test_back_to_back();
        test_priority();
        test_hold_change();
        test_ack_idle();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
